// File: rtl/forward_source_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : forward_source_pipeline
// Description : Holds the two in-flight writeback slots (slot1 = EX->MEM,
//               slot2 = MEM->WB) that feed the operand forwarding unit.
//               Detects load-use hazards against the decode source registers
//               and tracks outstanding load data. A sticky error flags a
//               memory that never returns load data.
// Ports       : clk, reset (sync, active-low)
//               ex_*                 EX-stage writeback candidate
//               flush                kill the EX-stage instruction
//               mem_ready            0 freezes both slots
//               load_data_valid/load_data   returned data for a slot1 load
//               decode_source_1/2    rs1/rs2 of the instruction in decode
//               destination_index_k, data_k, enable_k   forwarding sources
//               stall_request        hold decode/fetch
//               load_timeout_error   sticky, cleared only by reset
// Revision    : 1.0 - initial release
// ============================================================================
module forward_source_pipeline #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_write_enable,
    input  logic [4:0]      ex_destination_index,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_is_load,
    input  logic            flush,
    input  logic            mem_ready,
    input  logic            load_data_valid,
    input  logic [XLEN-1:0] load_data,
    input  logic [4:0]      decode_source_1,
    input  logic [4:0]      decode_source_2,
    output logic [4:0]      destination_index_1,
    output logic [4:0]      destination_index_2,
    output logic [XLEN-1:0] data_1,
    output logic [XLEN-1:0] data_2,
    output logic            enable_1,
    output logic            enable_2,
    output logic            stall_request,
    output logic            load_timeout_error
);

    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Slot storage
    logic            r_valid_1, r_we_1, r_pend_1;
    logic [4:0]      r_idx_1;
    logic [XLEN-1:0] r_data_1;
    logic            r_valid_2, r_we_2;
    logic [4:0]      r_idx_2;
    logic [XLEN-1:0] r_data_2;
    logic [CNT_W-1:0] r_cnt;
    logic            r_err;

    logic w_advance;
    logic w_capture_pend;
    logic w_hazard_slot1;
    logic w_hazard_ex;

    assign w_advance      = mem_ready && (r_state == ST_RUN);
    // A captured load with a destination write leaves slot1 waiting for data.
    assign w_capture_pend = !flush && ex_is_load && ex_write_enable;

    // Pending load in slot1 that decode wants to read.
    assign w_hazard_slot1 = r_pend_1 && (r_idx_1 != 5'd0) &&
                            ((decode_source_1 == r_idx_1) || (decode_source_2 == r_idx_1));
    // Classic load-use: the decode consumer must wait one bubble. The load
    // itself still advances into slot1; only decode/fetch are held.
    assign w_hazard_ex    = ex_is_load && ex_write_enable && (ex_destination_index != 5'd0) &&
                            ((decode_source_1 == ex_destination_index) ||
                             (decode_source_2 == ex_destination_index));

    assign stall_request = w_hazard_slot1 || w_hazard_ex ||
                           (r_state == ST_LOAD_WAIT) || !mem_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_advance && w_capture_pend) begin
                    w_state_next = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                if (load_data_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Slot datapath, timeout counter and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_1 <= 1'b0;
            r_we_1    <= 1'b0;
            r_pend_1  <= 1'b0;
            r_idx_1   <= 5'd0;
            r_data_1  <= '0;
            r_valid_2 <= 1'b0;
            r_we_2    <= 1'b0;
            r_idx_2   <= 5'd0;
            r_data_2  <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else if (r_state == ST_LOAD_WAIT) begin
            // Counter saturates; the error stays set once the limit is hit.
            if (r_cnt != CNT_W'(LOAD_TIMEOUT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_cnt >= CNT_W'(LOAD_TIMEOUT - 1)) begin
                r_err <= 1'b1;
            end
            if (load_data_valid) begin
                r_data_1 <= load_data;
                r_pend_1 <= 1'b0;
            end
        end else if (mem_ready) begin
            r_valid_2 <= r_valid_1;
            r_we_2    <= r_we_1;
            r_idx_2   <= r_idx_1;
            r_data_2  <= r_data_1;
            r_cnt     <= '0;
            if (flush) begin
                // Killed instruction becomes a clean bubble.
                r_valid_1 <= 1'b0;
                r_we_1    <= 1'b0;
                r_pend_1  <= 1'b0;
                r_idx_1   <= 5'd0;
                r_data_1  <= '0;
            end else begin
                r_valid_1 <= 1'b1;
                r_we_1    <= ex_write_enable;
                r_pend_1  <= w_capture_pend;
                r_idx_1   <= ex_destination_index;
                r_data_1  <= ex_result;
            end
        end
    end

    assign destination_index_1 = r_idx_1;
    assign destination_index_2 = r_idx_2;
    assign data_1              = r_data_1;
    assign data_2              = r_data_2;
    assign enable_1            = r_valid_1 && r_we_1 && (r_idx_1 != 5'd0) && !r_pend_1;
    assign enable_2            = r_valid_2 && r_we_2 && (r_idx_2 != 5'd0);
    assign load_timeout_error  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_forward_source_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_source_pipeline
// Description : Self-checking bench for forward_source_pipeline. A slot-level
//               reference model predicts every output each cycle; directed
//               scenarios add explicit expected constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_source_pipeline;

    localparam int XLEN         = 32;
    localparam int LOAD_TIMEOUT = 4;

    logic            clk;
    logic            reset;
    logic            ex_write_enable;
    logic [4:0]      ex_destination_index;
    logic [XLEN-1:0] ex_result;
    logic            ex_is_load;
    logic            flush;
    logic            mem_ready;
    logic            load_data_valid;
    logic [XLEN-1:0] load_data;
    logic [4:0]      decode_source_1;
    logic [4:0]      decode_source_2;
    logic [4:0]      destination_index_1;
    logic [4:0]      destination_index_2;
    logic [XLEN-1:0] data_1;
    logic [XLEN-1:0] data_2;
    logic            enable_1;
    logic            enable_2;
    logic            stall_request;
    logic            load_timeout_error;

    forward_source_pipeline #(
        .XLEN         (XLEN),
        .LOAD_TIMEOUT (LOAD_TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .ex_write_enable      (ex_write_enable),
        .ex_destination_index (ex_destination_index),
        .ex_result            (ex_result),
        .ex_is_load           (ex_is_load),
        .flush                (flush),
        .mem_ready            (mem_ready),
        .load_data_valid      (load_data_valid),
        .load_data            (load_data),
        .decode_source_1      (decode_source_1),
        .decode_source_2      (decode_source_2),
        .destination_index_1  (destination_index_1),
        .destination_index_2  (destination_index_2),
        .data_1               (data_1),
        .data_2               (data_2),
        .enable_1             (enable_1),
        .enable_2             (enable_2),
        .stall_request        (stall_request),
        .load_timeout_error   (load_timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: an instruction-level view of the two slots.
    typedef struct packed {
        bit        v;
        bit        we;
        bit        pend;   // load whose data has not come back
        bit [4:0]  idx;
        bit [31:0] data;
    } slot_t;

    slot_t m1, m2;
    bit    m_waiting;
    int    m_waited;
    bit    m_err;

    function automatic bit fwd_ok(slot_t s);
        return s.v && s.we && (s.idx != 0) && !s.pend;
    endfunction

    function automatic bit reads(bit [4:0] r);
        return (r != 0) && (decode_source_1 == r || decode_source_2 == r);
    endfunction

    function automatic bit exp_stall();
        bit a, b;
        a = m1.v && m1.pend && reads(m1.idx);
        b = ex_is_load && ex_write_enable && reads(ex_destination_index);
        return a || b || m_waiting || !mem_ready;
    endfunction

    task automatic model_clock();
        if (!reset) begin
            m1 = '0; m2 = '0; m_waiting = 0; m_waited = 0; m_err = 0;
        end else if (m_waiting) begin
            m_waited++;
            if (m_waited >= LOAD_TIMEOUT) m_err = 1;
            if (load_data_valid) begin
                m1.data   = load_data;
                m1.pend   = 0;
                m_waiting = 0;
            end
        end else if (mem_ready) begin
            m2 = m1;
            if (flush) begin
                m1 = '0;
            end else begin
                m1 = '{v: 1'b1, we: ex_write_enable, pend: ex_is_load && ex_write_enable,
                       idx: ex_destination_index, data: ex_result};
            end
            if (m1.pend) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
    endtask

    // Compare everything at the falling edge, then step model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_value("idx1",  32'(destination_index_1), 32'(m1.idx));
        check_value("idx2",  32'(destination_index_2), 32'(m2.idx));
        check_value("data1", data_1, m1.data);
        check_value("data2", data_2, m2.data);
        check_value("en1",   32'(enable_1), 32'(fwd_ok(m1)));
        check_value("en2",   32'(enable_2), 32'(fwd_ok(m2)));
        check_value("stall", 32'(stall_request), 32'(exp_stall()));
        check_value("err",   32'(load_timeout_error), 32'(m_err));
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        reset = 1; ex_write_enable = 0; ex_destination_index = 0; ex_result = 0;
        ex_is_load = 0; flush = 0; mem_ready = 1; load_data_valid = 0; load_data = 0;
        decode_source_1 = 0; decode_source_2 = 0;
    endtask

    task automatic alu(input bit [4:0] rd, input bit [31:0] val);
        ex_write_enable = 1; ex_is_load = 0; ex_destination_index = rd; ex_result = val;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        cycle();
        reset = 1;
    endtask

    initial begin
        m1 = '0; m2 = '0; m_waiting = 0; m_waited = 0; m_err = 0;
        idle();
        #1;
        // 1: reset with random inputs for 3 clocks
        for (int i = 0; i < 3; i++) begin
            reset = 0;
            ex_write_enable = 1'($urandom); ex_is_load = 1'($urandom);
            ex_destination_index = 5'($urandom); ex_result = $urandom;
            flush = 1'($urandom); mem_ready = 1'($urandom);
            load_data_valid = 1'($urandom); load_data = $urandom;
            @(posedge clk); model_clock(); #1;
        end
        idle();
        check_value("rst_idx1", 32'(destination_index_1), 0);
        check_value("rst_data1", data_1, 0);
        check_value("rst_en", 32'({enable_1, enable_2}), 0);
        check_value("rst_stall", 32'(stall_request), 0);
        check_value("rst_err", 32'(load_timeout_error), 0);

        // 2: ALU chain
        alu(5, 32'h11); cycle();
        check_value("chain_idx1", 32'(destination_index_1), 5);
        check_value("chain_data1", data_1, 32'h11);
        check_value("chain_en1", 32'(enable_1), 1);
        alu(6, 32'h22); cycle();
        check_value("chain_idx1b", 32'(destination_index_1), 6);
        check_value("chain_data1b", data_1, 32'h22);
        check_value("chain_idx2", 32'(destination_index_2), 5);
        check_value("chain_data2", data_2, 32'h11);
        check_value("chain_en12", 32'({enable_1, enable_2}), 3);

        // 3: load-use
        idle();
        ex_write_enable = 1; ex_is_load = 1; ex_destination_index = 7; decode_source_1 = 7;
        #1;
        check_value("lu_stall_ex", 32'(stall_request), 1);
        cycle();
        ex_write_enable = 0; ex_is_load = 0;
        check_value("lu_idx1", 32'(destination_index_1), 7);
        check_value("lu_en1_pend", 32'(enable_1), 0);
        for (int i = 0; i < 3; i++) cycle();
        load_data_valid = 1; load_data = 32'hDEAD;
        cycle();
        load_data_valid = 0;
        check_value("lu_en1", 32'(enable_1), 1);
        check_value("lu_data1", data_1, 32'hDEAD);
        check_value("lu_stall_drop", 32'(stall_request), 0);
        cycle();
        do_reset();

        // 4: x0 and flush
        alu(3, 32'h33); cycle();
        alu(9, 32'h99); flush = 1; cycle(); flush = 0;
        check_value("fl_en1", 32'(enable_1), 0);
        check_value("fl_idx2", 32'(destination_index_2), 3);
        check_value("fl_en2", 32'(enable_2), 1);
        alu(0, 32'h55); cycle();
        check_value("x0_en1", 32'(enable_1), 0);
        idle(); cycle();

        // 5: timeout
        ex_write_enable = 1; ex_is_load = 1; ex_destination_index = 8; cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();
        check_value("to_err_early", 32'(load_timeout_error), 0);
        cycle();
        check_value("to_err_set", 32'(load_timeout_error), 1);
        cycle(); cycle();
        load_data_valid = 1; load_data = 32'hBEEF; cycle(); load_data_valid = 0;
        check_value("to_err_sticky", 32'(load_timeout_error), 1);
        check_value("to_en1", 32'(enable_1), 1);
        do_reset();
        check_value("to_err_clear", 32'(load_timeout_error), 0);

        // 6: backpressure
        alu(10, 32'hA); cycle();
        alu(11, 32'hB); cycle();
        alu(12, 32'hC); mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_value("bp_idx1", 32'(destination_index_1), 11);
            check_value("bp_idx2", 32'(destination_index_2), 10);
            check_value("bp_stall", 32'(stall_request), 1);
        end
        mem_ready = 1; cycle();
        check_value("bp_rel_idx1", 32'(destination_index_1), 12);
        check_value("bp_rel_idx2", 32'(destination_index_2), 11);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset                = ($urandom_range(0, 49) != 0);
            ex_write_enable      = ($urandom_range(0, 3) != 0);
            ex_is_load           = ($urandom_range(0, 9) < 3);
            ex_destination_index = 5'($urandom_range(0, 7));
            ex_result            = $urandom;
            flush                = ($urandom_range(0, 9) == 0);
            mem_ready            = ($urandom_range(0, 9) < 8);
            load_data_valid      = ($urandom_range(0, 9) < 3);
            load_data            = $urandom;
            decode_source_1      = 5'($urandom_range(0, 7));
            decode_source_2      = 5'($urandom_range(0, 7));
            #1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
